// File: rtl/apb_ahb_pkg.sv
// Shared AHB encodings and the bridge FSM state type for the APB/AHB bridge pair.
package apb_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_e;

endpackage

// File: rtl/apb2ahb_bridge.sv
// APB3 completer that turns each APB access into one 32-bit AHB SINGLE transfer,
// stalling APB with pready until the AHB data phase completes.
module apb2ahb_bridge
    import apb_ahb_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 40,
    parameter logic [ADDR_WIDTH-1:0] AHB_BASE   = '0,
    parameter logic [3:0]            HPROT_VAL  = 4'b0011,
    parameter int                    RETRY_MAX  = 4
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [31:0]           pwdata,
    output logic [31:0]           prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic [1:0]            htrans,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic [2:0]            hburst,
    output logic [3:0]            hprot,
    output logic                  hmastlock,
    output logic [31:0]           hwdata,
    input  logic [31:0]           hrdata,
    input  logic                  hready,
    input  logic [1:0]            hresp
);

    localparam int                CNT_W       = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
    localparam logic [CNT_W-1:0]  RETRY_LIMIT = CNT_W'(RETRY_MAX);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   haddr_q;
    logic                    hwrite_q;
    logic [31:0]             hwdata_q;
    logic [31:0]             prdata_q;
    logic                    err_q;
    logic [CNT_W-1:0]        retry_cnt;

    logic capture;
    logic set_err;
    logic latch_rd;
    logic retry_inc;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        set_err   = 1'b0;
        latch_rd  = 1'b0;
        retry_inc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // A lone access phase without a preceding setup phase is ignored.
                if (psel && !penable) begin
                    capture = 1'b1;
                    state_d = (paddr[1:0] != 2'b00) ? ST_DONE : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (hready) state_d = ST_DATA;
            end
            ST_DATA: begin
                // The first (hready=0) cycle of a two-cycle response is simply waited through.
                if (hready) begin
                    case (hresp)
                        HRESP_OKAY: begin
                            latch_rd = !hwrite_q;
                            state_d  = ST_DONE;
                        end
                        HRESP_ERROR: begin
                            set_err = 1'b1;
                            state_d = ST_DONE;
                        end
                        default: begin
                            if (retry_cnt < RETRY_LIMIT) begin
                                retry_inc = 1'b1;
                                state_d   = ST_ADDR;
                            end else begin
                                set_err = 1'b1;
                                state_d = ST_DONE;
                            end
                        end
                    endcase
                end
            end
            ST_DONE: begin
                // Leaves after one cycle even if psel was dropped, so the bridge never hangs.
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            haddr_q   <= '0;
            hwrite_q  <= 1'b0;
            hwdata_q  <= '0;
            prdata_q  <= '0;
            err_q     <= 1'b0;
            retry_cnt <= '0;
        end else begin
            if (capture) begin
                haddr_q   <= AHB_BASE + paddr;
                hwrite_q  <= pwrite;
                hwdata_q  <= pwdata;
                err_q     <= (paddr[1:0] != 2'b00);
                retry_cnt <= '0;
            end
            if (set_err)   err_q     <= 1'b1;
            if (retry_inc) retry_cnt <= retry_cnt + 1'b1;
            if (latch_rd)  prdata_q  <= hrdata;
        end
    end

    assign htrans    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr     = haddr_q;
    assign hwrite    = hwrite_q;
    assign hwdata    = hwdata_q;
    assign hsize     = HSIZE_WORD;
    assign hburst    = HBURST_SINGLE;
    assign hprot     = HPROT_VAL;
    assign hmastlock = 1'b0;

    assign prdata  = prdata_q;
    assign pready  = (state_q == ST_DONE) && psel && penable;
    assign pslverr = pready && err_q;

endmodule

// File: tb/tb_apb2ahb_bridge.sv
// Directed bench for apb2ahb_bridge: APB master and AHB slave responses are scripted per cycle.
module tb_apb2ahb_bridge;
    import apb_ahb_pkg::*;

    localparam int          AW   = 40;
    localparam logic [AW-1:0] BASE = 40'h01_0000_0000;
    localparam int          RMAX = 4;

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [31:0]   pwdata = '0;
    logic [31:0]   prdata;
    logic          pready, pslverr;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite, hmastlock;
    logic [2:0]    hsize, hburst;
    logic [3:0]    hprot;
    logic [31:0]   hwdata;
    logic [31:0]   hrdata = '0;
    logic          hready = 1'b1;
    logic [1:0]    hresp = 2'b00;

    typedef struct packed {
        logic        rdy;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } slv_t;

    slv_t slv_q[$];
    int   checks = 0;
    int   errors = 0;

    apb2ahb_bridge #(
        .ADDR_WIDTH(AW), .AHB_BASE(BASE), .HPROT_VAL(4'b0011), .RETRY_MAX(RMAX)
    ) dut (
        .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata), .hrdata(hrdata),
        .hready(hready), .hresp(hresp)
    );

    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic push(input logic rdy, input logic [1:0] resp, input logic [31:0] rd);
        slv_t s;
        s.rdy   = rdy;
        s.resp  = resp;
        s.rdata = rd;
        slv_q.push_back(s);
    endtask

    task automatic apply_slave();
        slv_t s;
        if (slv_q.size() > 0) s = slv_q.pop_front();
        else begin
            s.rdy = 1'b1; s.resp = HRESP_OKAY; s.rdata = 32'h0;
        end
        hready = s.rdy;
        hresp  = s.resp;
        hrdata = s.rdata;
    endtask

    // One APB access: setup at T0, access phase from T1; slave script applied from T1.
    task automatic do_access(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                             input logic [AW-1:0] exp_haddr, output int lat, output int nonseq,
                             output int bad_addr, output logic slverr, output logic [31:0] rdata);
        lat = -1; nonseq = 0; bad_addr = 0; slverr = 1'b0; rdata = 'x;
        tick();
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        hready = 1'b1; hresp = HRESP_OKAY;
        @(negedge pclk);
        if (htrans === HTRANS_NONSEQ) nonseq++;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            tick();
            penable = 1'b1;
            apply_slave();
            @(negedge pclk);
            if (htrans === HTRANS_NONSEQ && hready) begin
                nonseq++;
                if (haddr !== exp_haddr) bad_addr++;
            end
            if (pready === 1'b1) begin
                lat = cyc; slverr = pslverr; rdata = prdata;
                break;
            end
        end
        tick();
        psel = 1'b0; penable = 1'b0; hready = 1'b1; hresp = HRESP_OKAY;
        slv_q.delete();
        checks++;
        if (lat < 0) begin
            errors++;
            $display("FAIL timeout paddr=%h: pready got never, required within 60 cycles", addr);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        checks++;
        if ({prdata, pready, pslverr, haddr, htrans, hwrite, hwdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got prdata=%h pready=%b pslverr=%b haddr=%h htrans=%b hwrite=%b hwdata=%h required all 0",
                     prdata, pready, pslverr, haddr, htrans, hwrite, hwdata);
        end
        checks++;
        if ({hsize, hburst, hprot, hmastlock} !== {3'b010, 3'b000, 4'b0011, 1'b0}) begin
            errors++;
            $display("FAIL constants got hsize=%b hburst=%b hprot=%b hmastlock=%b required 010 000 0011 0",
                     hsize, hburst, hprot, hmastlock);
        end
        tick();
        presetn = 1'b1;
    endtask

    task automatic test_write_zero_wait();
        tick();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 40'h10; pwdata = 32'hDEADBEEF;
        hready = 1'b1; hresp = HRESP_OKAY;
        @(negedge pclk);
        checks++;
        if (htrans !== HTRANS_IDLE || pready !== 1'b0) begin
            errors++;
            $display("FAIL wr_t0 got htrans=%b pready=%b required 00 0", htrans, pready);
        end
        tick();
        penable = 1'b1;
        @(negedge pclk);
        checks++;
        if (htrans !== HTRANS_NONSEQ || haddr !== 40'h01_0000_0010 || hwrite !== 1'b1) begin
            errors++;
            $display("FAIL wr_t1 got htrans=%b haddr=%h hwrite=%b required 10 0100000010 1", htrans, haddr, hwrite);
        end
        tick();
        @(negedge pclk);
        checks++;
        if (htrans !== HTRANS_IDLE || hwdata !== 32'hDEADBEEF || pready !== 1'b0) begin
            errors++;
            $display("FAIL wr_t2 got htrans=%b hwdata=%h pready=%b required 00 deadbeef 0", htrans, hwdata, pready);
        end
        tick();
        @(negedge pclk);
        checks++;
        if (pready !== 1'b1 || pslverr !== 1'b0) begin
            errors++;
            $display("FAIL wr_t3 got pready=%b pslverr=%b required 1 0", pready, pslverr);
        end
        tick();
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        checks++;
        if (pready !== 1'b0 || htrans !== HTRANS_IDLE) begin
            errors++;
            $display("FAIL wr_t4 got pready=%b htrans=%b required 0 00", pready, htrans);
        end
    endtask

    task automatic test_read_wait();
        int lat, ns, bad; logic se; logic [31:0] rd;
        push(1'b1, HRESP_OKAY, 32'h0);
        push(1'b0, HRESP_OKAY, 32'hAAAA5555);
        push(1'b0, HRESP_OKAY, 32'hAAAA5555);
        push(1'b1, HRESP_OKAY, 32'h12345678);
        do_access(1'b0, 40'h20, 32'h0, BASE + 40'h20, lat, ns, bad, se, rd);
        checks++;
        if (lat != 5 || ns != 1 || bad != 0 || se !== 1'b0 || rd !== 32'h12345678) begin
            errors++;
            $display("FAIL rd_wait got lat=%0d nonseq=%0d badaddr=%0d pslverr=%b prdata=%h required 5 1 0 0 12345678",
                     lat, ns, bad, se, rd);
        end
    endtask

    task automatic test_read_error();
        int lat, ns, bad; logic se; logic [31:0] rd;
        push(1'b1, HRESP_OKAY,  32'h0);
        push(1'b0, HRESP_ERROR, 32'hCAFEF00D);
        push(1'b1, HRESP_ERROR, 32'hCAFEF00D);
        do_access(1'b0, 40'h24, 32'h0, BASE + 40'h24, lat, ns, bad, se, rd);
        checks++;
        if (lat != 4 || ns != 1 || se !== 1'b1 || rd !== 32'h12345678) begin
            errors++;
            $display("FAIL rd_error got lat=%0d nonseq=%0d pslverr=%b prdata=%h required 4 1 1 12345678",
                     lat, ns, se, rd);
        end
    endtask

    task automatic test_retry_ok();
        int lat, ns, bad; logic se; logic [31:0] rd;
        for (int i = 0; i < 2; i++) begin
            push(1'b1, HRESP_OKAY,  32'h0);
            push(1'b0, HRESP_RETRY, 32'h0);
            push(1'b1, HRESP_RETRY, 32'h0);
        end
        push(1'b1, HRESP_OKAY, 32'h0);
        push(1'b1, HRESP_OKAY, 32'h0);
        do_access(1'b1, 40'h30, 32'h0BADF00D, BASE + 40'h30, lat, ns, bad, se, rd);
        checks++;
        if (lat != 9 || ns != 3 || bad != 0 || se !== 1'b0) begin
            errors++;
            $display("FAIL retry_ok got lat=%0d nonseq=%0d badaddr=%0d pslverr=%b required 9 3 0 0", lat, ns, bad, se);
        end
    endtask

    task automatic test_retry_exhaust();
        int lat, ns, bad; logic se; logic [31:0] rd;
        for (int i = 0; i < RMAX + 1; i++) begin
            push(1'b1, HRESP_OKAY, 32'h0);
            push(1'b0, (i % 2 == 0) ? HRESP_RETRY : HRESP_SPLIT, 32'h0);
            push(1'b1, (i % 2 == 0) ? HRESP_RETRY : HRESP_SPLIT, 32'h0);
        end
        do_access(1'b1, 40'h34, 32'h1, BASE + 40'h34, lat, ns, bad, se, rd);
        checks++;
        if (lat != 16 || ns != 5 || bad != 0 || se !== 1'b1) begin
            errors++;
            $display("FAIL retry_max got lat=%0d nonseq=%0d badaddr=%0d pslverr=%b required 16 5 0 1", lat, ns, bad, se);
        end
    endtask

    task automatic test_misaligned();
        int lat, ns, bad; logic se; logic [31:0] rd;
        do_access(1'b0, 40'h3, 32'h0, BASE + 40'h3, lat, ns, bad, se, rd);
        checks++;
        if (lat != 1 || ns != 0 || se !== 1'b1 || rd !== 32'h12345678) begin
            errors++;
            $display("FAIL misaligned got lat=%0d nonseq=%0d pslverr=%b prdata=%h required 1 0 1 12345678",
                     lat, ns, se, rd);
        end
    endtask

    task automatic test_ignore_access_in_idle();
        int bad = 0;
        tick();
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 40'h50;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            if (htrans !== HTRANS_IDLE || pready !== 1'b0) bad++;
            tick();
        end
        psel = 1'b0; penable = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_access got %0d active cycles required 0", bad);
        end
    endtask

    task automatic test_addr_wrap();
        int lat, ns, bad; logic se; logic [31:0] rd;
        do_access(1'b1, 40'hFF_0000_0010, 32'h1, 40'h00_0000_0010, lat, ns, bad, se, rd);
        checks++;
        if (lat != 3 || ns != 1 || bad != 0 || se !== 1'b0) begin
            errors++;
            $display("FAIL addr_wrap got lat=%0d nonseq=%0d badaddr=%0d pslverr=%b required 3 1 0 0", lat, ns, bad, se);
        end
    endtask

    task automatic test_reset_in_addr();
        int lat, ns, bad; logic se; logic [31:0] rd;
        tick();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 40'h60; pwdata = 32'h5A5A5A5A;
        tick();
        penable = 1'b1; hready = 1'b0;
        #2;
        checks++;
        if (htrans !== HTRANS_NONSEQ) begin
            errors++;
            $display("FAIL rst_pre got htrans=%b required 10", htrans);
        end
        presetn = 1'b0;
        #1;
        checks++;
        if (htrans !== HTRANS_IDLE || pready !== 1'b0 || dut.state_q !== ST_IDLE || haddr !== '0) begin
            errors++;
            $display("FAIL rst_async got htrans=%b pready=%b state=%0d haddr=%h required 00 0 0 0",
                     htrans, pready, dut.state_q, haddr);
        end
        tick();
        psel = 1'b0; penable = 1'b0; hready = 1'b1;
        tick();
        presetn = 1'b1;
        do_access(1'b1, 40'h40, 32'h600DF00D, BASE + 40'h40, lat, ns, bad, se, rd);
        checks++;
        if (lat != 3 || ns != 1 || bad != 0 || se !== 1'b0 || hwdata !== 32'h600DF00D) begin
            errors++;
            $display("FAIL rst_recover got lat=%0d nonseq=%0d badaddr=%0d pslverr=%b hwdata=%h required 3 1 0 0 600df00d",
                     lat, ns, bad, se, hwdata);
        end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_read_error();
        test_retry_ok();
        test_retry_exhaust();
        test_misaligned();
        test_ignore_access_in_idle();
        test_addr_wrap();
        test_reset_in_addr();
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb2ahb_bridge.md
Name: apb2ahb_bridge

Overview:
APB3 completer that converts each APB access into a single 32-bit AHB transfer as an AHB master, so that APB-side agents (debug/PMU sequencers, test stimulus) can reach AHB memory. It is the reverse of the subsystem's AHB-to-APB path. Accesses are non-pipelined and one at a time. APB is stalled with pready until the AHB data phase completes. AHB RETRY/SPLIT responses are retried a bounded number of times.

Parameters:
ADDR_WIDTH, 40, width of paddr and haddr
AHB_BASE, 40'h0, added to paddr to form haddr (modulo 2^ADDR_WIDTH)
HPROT_VAL, 4'b0011, constant hprot driven on every transfer
RETRY_MAX, 4, maximum number of re-issues on RETRY/SPLIT before returning an error

Ports:
pclk  in  1  single clock for both the APB and AHB sides
presetn  in  1  asynchronous, active-low reset
psel  in  1  APB select
penable  in  1  APB access phase
pwrite  in  1  APB direction
paddr  in  ADDR_WIDTH  APB address
pwdata  in  32  APB write data
prdata  out  32  APB read data, registered
pready  out  1  APB completion
pslverr  out  1  APB error, valid when pready=1
haddr  out  ADDR_WIDTH  AHB address
htrans  out  2  AHB transfer type; only IDLE=00 and NONSEQ=10 are used
hwrite  out  1  AHB direction
hsize  out  3  constant 3'b010 (word)
hburst  out  3  constant 3'b000 (SINGLE)
hprot  out  4  constant HPROT_VAL
hmastlock  out  1  constant 0
hwdata  out  32  AHB write data, driven in the data phase
hrdata  in  32  AHB read data
hready  in  1  AHB ready
hresp  in  2  AHB response: 00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT

Behaviour:
- Reset values: prdata=0, pready=0, pslverr=0, haddr=0, htrans=00, hwrite=0, hwdata=0. The FSM resets to IDLE and the retry counter to 0.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - On psel=1 and penable=0 (setup phase), capture paddr, pwrite and pwdata. Clear err. Clear retry_cnt.
  - If paddr[1:0]!=0, set err=1 and go to DONE. No AHB transfer is issued.
  - Otherwise go to ADDR.
- ADDR:
  - Drive htrans=NONSEQ, haddr=AHB_BASE+captured addr, hwrite=captured pwrite.
  - Hold these until a cycle with hready=1, then go to DATA.
- DATA:
  - Drive htrans=IDLE. Drive hwdata=captured data.
  - Wait for a cycle with hready=1, then decode hresp:
    - OKAY: go to DONE; if the access is a read, latch prdata=hrdata.
    - ERROR: set err=1 and go to DONE. prdata is unchanged.
    - RETRY/SPLIT with retry_cnt<RETRY_MAX: increment retry_cnt and go back to ADDR (re-issue the same transfer).
    - RETRY/SPLIT with retry_cnt==RETRY_MAX: set err=1 and go to DONE.
  - The first ERROR/RETRY/SPLIT cycle with hready=0 is only waited through.
- DONE:
  - Drive pready=1 and pslverr=err for exactly one cycle (the access cycle with psel=penable=1), then go to IDLE.
  - pready=0 in every other state.
- Minimum latency, zero-wait AHB:
  - setup cycle T0 (IDLE), ADDR at T1, DATA at T2, pready=1 at T3.
  - The APB access phase is therefore 3 cycles.
- If psel drops mid-transaction (protocol violation): the AHB transfer still completes. In DONE the bridge returns to IDLE without asserting pready. prdata holds its latched value.
- If psel=1 and penable=1 arrive while the FSM is in IDLE, they are ignored (no setup phase was seen).
- haddr addition wraps modulo 2^ADDR_WIDTH.
- htrans never issues SEQ or BUSY. hwdata is don't-care for reads and is driven as captured data regardless.
- Asynchronous reset during any state returns all state and outputs to reset values immediately. An in-flight AHB transfer is abandoned.

Decomposition:
- Shared package apb_ahb_pkg holds:
  - HTRANS_IDLE/NONSEQ, HRESP_OKAY/ERROR/RETRY/SPLIT
  - HSIZE_WORD, HBURST_SINGLE
  - the FSM state enum
- No sub-module. The design is a single FSM plus a retry counter and capture registers.

Test Plan:
- Write, paddr=0x10, pwdata=0xDEADBEEF, AHB_BASE=0x1_0000_0000, zero-wait slave -> haddr=0x1_0000_0010, htrans=10 at T1, hwdata=0xDEADBEEF at T2, pready=1 and pslverr=0 at T3.
- Read, paddr=0x20, slave inserts 2 wait states in the data phase with hrdata=0x12345678 -> pready rises on the cycle after the final hready=1, prdata=0x12345678.
- Read where the slave returns ERROR (hready=0 then hready=1 with hresp=01) -> pready=1 and pslverr=1 one cycle later, prdata unchanged.
- Slave returns RETRY twice, then OKAY -> exactly 3 NONSEQ address phases to the same haddr, pslverr=0. Slave returns RETRY on every attempt with RETRY_MAX=4 -> exactly 5 address phases, then pslverr=1.
- Misaligned paddr=0x3 -> htrans stays 00 throughout, pready=1 and pslverr=1 at T1.
- Assert presetn low during ADDR -> htrans=00, pready=0, state IDLE immediately. A fresh write after reset release completes normally.
